// File: rtl/axi_burst_checker_pkg.sv
// Shared types and the test-pattern definition for the AXI burst checker.
// The pattern is defined once here so write data and read expectations cannot drift apart.
package axi_burst_checker_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WR_ADDR,
      ST_WR_DATA,
      ST_WR_RESP,
      ST_RD_ADDR,
      ST_RD_DATA,
      ST_FIN
   } state_e;

   localparam logic [1:0] RESP_OKAY = 2'b00;
   localparam int PAT_MAX_W = 512;

   // Computed at the widest legal data width; callers truncate to DATA_W.
   function automatic logic [PAT_MAX_W-1:0] pat(input logic [PAT_MAX_W-1:0] seed,
                                                input logic [31:0]          b,
                                                input logic [31:0]          k,
                                                input logic [31:0]          blen);
      return seed + PAT_MAX_W'(b * blen + k);
   endfunction

endpackage

// File: rtl/axi_burst_checker_pat.sv
// Burst/beat counters with address and pattern generation, shared by the write and read passes.
// Outputs are combinational from the counters, so they stay stable until the FSM advances them.
module axi_burst_checker_pat
   import axi_burst_checker_pkg::*;
#(
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 32,
   parameter int BURST_LEN = 8,
   parameter int NB_W      = 8
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              rewind_i,
   input  logic              beat_adv_i,
   input  logic              burst_adv_i,
   input  logic [ADDR_W-1:0] base_i,
   input  logic [DATA_W-1:0] seed_i,
   input  logic [NB_W-1:0]   num_i,
   output logic [ADDR_W-1:0] addr_o,
   output logic [DATA_W-1:0] data_o,
   output logic              last_beat_o,
   output logic              last_burst_o
);

   localparam int KW          = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
   localparam int BURST_BYTES = BURST_LEN * DATA_W / 8;

   logic [NB_W-1:0] b_q, b_d;
   logic [KW-1:0]   k_q, k_d;

   assign last_beat_o  = (k_q == KW'(BURST_LEN - 1));
   assign last_burst_o = (b_q == num_i - NB_W'(1));
   assign addr_o       = base_i + ADDR_W'(b_q) * ADDR_W'(BURST_BYTES);
   assign data_o       = DATA_W'(pat(PAT_MAX_W'(seed_i), 32'(b_q), 32'(k_q), 32'(BURST_LEN)));

   // The beat index parks on the last beat so overrun beats cannot wrap it.
   always_comb begin
      b_d = b_q;
      k_d = k_q;
      if (rewind_i) begin
         b_d = '0;
         k_d = '0;
      end else if (burst_adv_i) begin
         b_d = b_q + NB_W'(1);
         k_d = '0;
      end else if (beat_adv_i && !last_beat_o) begin
         k_d = k_q + KW'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         b_q <= '0;
         k_q <= '0;
      end else begin
         b_q <= b_d;
         k_q <= k_d;
      end
   end

endmodule

// File: rtl/axi_burst_checker.sv
// AXI4 memory-test master: writes a seeded incrementing pattern, reads it back and compares.
// One transaction outstanding; every VALID holds its payload until READY.
module axi_burst_checker
   import axi_burst_checker_pkg::*;
#(
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 32,
   parameter int BURST_LEN = 8,
   parameter int NB_W      = 8,
   parameter int CNT_W     = 16
) (
   input  logic              ACLK,
   input  logic              ARESET,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [NB_W-1:0]   num_bursts,
   input  logic [DATA_W-1:0] seed,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [CNT_W-1:0]  err_cnt,
   output logic              resp_err,
   output logic [ADDR_W-1:0] M_AXI_AWADDR,
   output logic [7:0]        M_AXI_AWLEN,
   output logic              M_AXI_AWVALID,
   input  logic              M_AXI_AWREADY,
   output logic [DATA_W-1:0] M_AXI_WDATA,
   output logic              M_AXI_WLAST,
   output logic              M_AXI_WVALID,
   input  logic              M_AXI_WREADY,
   input  logic [1:0]        M_AXI_BRESP,
   input  logic              M_AXI_BVALID,
   output logic              M_AXI_BREADY,
   output logic [ADDR_W-1:0] M_AXI_ARADDR,
   output logic [7:0]        M_AXI_ARLEN,
   output logic              M_AXI_ARVALID,
   input  logic              M_AXI_ARREADY,
   input  logic [DATA_W-1:0] M_AXI_RDATA,
   input  logic [1:0]        M_AXI_RRESP,
   input  logic              M_AXI_RLAST,
   input  logic              M_AXI_RVALID,
   output logic              M_AXI_RREADY
);

   localparam int BURST_BYTES = BURST_LEN * DATA_W / 8;
   localparam int ALIGN_W     = $clog2(BURST_BYTES + 1) - 1;
   localparam logic [ADDR_W-1:0] LOW_MASK = ADDR_W'((64'd1 << ALIGN_W) - 64'd1);

   if (BURST_LEN < 1 || BURST_LEN > 256 || BURST_BYTES > 4096) begin : g_bad_cfg
      $error("axi_burst_checker: BURST_LEN out of range or burst exceeds 4 KiB");
   end

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] base_q;
   logic [NB_W-1:0]   num_q;
   logic [DATA_W-1:0] seed_q;
   logic              busy_q, done_q, resp_q, overrun_q, overrun_d;
   logic [CNT_W-1:0]  err_q, err_d;
   logic [CNT_W:0]    err_sum;
   logic [1:0]        err_inc;
   logic              resp_hit, rewind, beat_adv, burst_adv, accept;
   logic [ADDR_W-1:0] gen_addr;
   logic [DATA_W-1:0] gen_data;
   logic              last_beat, last_burst;

   axi_burst_checker_pat #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_LEN(BURST_LEN), .NB_W(NB_W)
   ) u_pat (
      .clk_i(ACLK), .rst_i(ARESET), .rewind_i(rewind), .beat_adv_i(beat_adv),
      .burst_adv_i(burst_adv), .base_i(base_q), .seed_i(seed_q), .num_i(num_q),
      .addr_o(gen_addr), .data_o(gen_data), .last_beat_o(last_beat),
      .last_burst_o(last_burst)
   );

   assign accept        = (state_q == ST_IDLE) && start;
   assign busy          = busy_q;
   assign done          = done_q;
   assign err_cnt       = err_q;
   assign resp_err      = resp_q;
   assign pass          = (err_q == '0) && !resp_q;
   assign M_AXI_AWADDR  = gen_addr;
   assign M_AXI_ARADDR  = gen_addr;
   assign M_AXI_AWLEN   = 8'(BURST_LEN - 1);
   assign M_AXI_ARLEN   = 8'(BURST_LEN - 1);
   assign M_AXI_WDATA   = gen_data;
   assign M_AXI_WLAST   = last_beat;

   always_comb begin
      state_d       = state_q;
      overrun_d     = overrun_q;
      M_AXI_AWVALID = 1'b0;
      M_AXI_WVALID  = 1'b0;
      M_AXI_BREADY  = 1'b0;
      M_AXI_ARVALID = 1'b0;
      M_AXI_RREADY  = 1'b0;
      rewind        = 1'b0;
      beat_adv      = 1'b0;
      burst_adv     = 1'b0;
      resp_hit      = 1'b0;
      err_inc       = 2'd0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               rewind  = 1'b1;
               state_d = (num_bursts == '0) ? ST_FIN : ST_WR_ADDR;
            end
         end
         ST_WR_ADDR: begin
            M_AXI_AWVALID = 1'b1;
            if (M_AXI_AWREADY) state_d = ST_WR_DATA;
         end
         ST_WR_DATA: begin
            M_AXI_WVALID = 1'b1;
            if (M_AXI_WREADY) begin
               if (last_beat) state_d = ST_WR_RESP;
               else           beat_adv = 1'b1;
            end
         end
         ST_WR_RESP: begin
            M_AXI_BREADY = 1'b1;
            if (M_AXI_BVALID) begin
               resp_hit = (M_AXI_BRESP != RESP_OKAY);
               if (last_burst) begin
                  rewind  = 1'b1;
                  state_d = ST_RD_ADDR;
               end else begin
                  burst_adv = 1'b1;
                  state_d   = ST_WR_ADDR;
               end
            end
         end
         ST_RD_ADDR: begin
            M_AXI_ARVALID = 1'b1;
            if (M_AXI_ARREADY) state_d = ST_RD_DATA;
         end
         ST_RD_DATA: begin
            M_AXI_RREADY = 1'b1;
            if (M_AXI_RVALID) begin
               resp_hit = (M_AXI_RRESP != RESP_OKAY);
               // Beats past a missing RLAST were already charged once; ignore their data.
               if (!overrun_q) begin
                  if (M_AXI_RDATA != gen_data)     err_inc = err_inc + 2'd1;
                  if (M_AXI_RLAST && !last_beat)   err_inc = err_inc + 2'd1;
                  if (!M_AXI_RLAST && last_beat) begin
                     err_inc   = err_inc + 2'd1;
                     overrun_d = 1'b1;
                  end
               end
               if (M_AXI_RLAST) begin
                  overrun_d = 1'b0;
                  if (last_burst) begin
                     state_d = ST_FIN;
                  end else begin
                     burst_adv = 1'b1;
                     state_d   = ST_RD_ADDR;
                  end
               end else begin
                  beat_adv = 1'b1;
               end
            end
         end
         ST_FIN:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   assign err_sum = {1'b0, err_q} + (CNT_W + 1)'(err_inc);
   assign err_d   = err_sum[CNT_W] ? '1 : err_sum[CNT_W-1:0];

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         state_q   <= ST_IDLE;
         overrun_q <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         resp_q    <= 1'b0;
         err_q     <= '0;
         base_q    <= '0;
         num_q     <= '0;
         seed_q    <= '0;
      end else begin
         state_q   <= state_d;
         overrun_q <= overrun_d;
         done_q    <= (state_q == ST_FIN);
         if (accept) begin
            busy_q <= 1'b1;
            err_q  <= '0;
            resp_q <= 1'b0;
            base_q <= base_addr & ~LOW_MASK;
            num_q  <= num_bursts;
            seed_q <= seed;
         end else begin
            if (state_q == ST_FIN) busy_q <= 1'b0;
            err_q <= err_d;
            if (resp_hit) resp_q <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_axi_burst_checker.sv
// Directed bench for axi_burst_checker with a behavioural AXI memory slave.
// Slave faults (bit flips, bad responses, RLAST errors, backpressure) are set per step.
module tb_axi_burst_checker;

   logic        ACLK = 1'b0;
   logic        ARESET = 1'b1;
   logic        start = 1'b0;
   logic [31:0] base_addr = '0;
   logic [7:0]  num_bursts = '0;
   logic [31:0] seed = '0;
   logic        busy, done, pass, resp_err;
   logic [15:0] err_cnt;
   logic [31:0] M_AXI_AWADDR, M_AXI_ARADDR, M_AXI_WDATA;
   logic [7:0]  M_AXI_AWLEN, M_AXI_ARLEN;
   logic        M_AXI_AWVALID, M_AXI_WLAST, M_AXI_WVALID, M_AXI_BREADY;
   logic        M_AXI_ARVALID, M_AXI_RREADY;
   logic        M_AXI_AWREADY = 1'b0, M_AXI_WREADY = 1'b0, M_AXI_ARREADY = 1'b0;
   logic        M_AXI_BVALID = 1'b0, M_AXI_RVALID = 1'b0, M_AXI_RLAST = 1'b0;
   logic [1:0]  M_AXI_BRESP = 2'b00, M_AXI_RRESP = 2'b00;
   logic [31:0] M_AXI_RDATA = '0;

   axi_burst_checker dut (
      .ACLK(ACLK), .ARESET(ARESET), .start(start), .base_addr(base_addr),
      .num_bursts(num_bursts), .seed(seed), .busy(busy), .done(done), .pass(pass),
      .err_cnt(err_cnt), .resp_err(resp_err),
      .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWLEN(M_AXI_AWLEN),
      .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
      .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WLAST(M_AXI_WLAST),
      .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
      .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY),
      .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARLEN(M_AXI_ARLEN),
      .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
      .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP), .M_AXI_RLAST(M_AXI_RLAST),
      .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY)
   );

   always #5 ACLK = ~ACLK;

   // Slave configuration, written only by the stimulus block.
   bit bp = 1'b0;
   int flip_b = -1, flip_k = -1, bresp_b = -1, early_b = -1, early_k = -1, late_b = -1;
   int aw0 = 0, ar0 = 0;

   // Slave state, written only by the posedge block.
   logic [31:0] mem [0:255];
   logic [31:0] wr_addr = '0, rd_addr = '0, aw_prev = '0, ar_prev = '0;
   logic [32:0] w_prev = '0;
   int  wbeat = 0, rbeat = 0, aw_cnt = 0, ar_cnt = 0, b_cnt = 0;
   int  wlast_bad = 0, stab_viol = 0;
   bit  b_pend = 0, r_act = 0, rv_hold = 0, aw_hold = 0, w_hold = 0, ar_hold = 0;

   int checks = 0;
   int errors = 0;

   always @(posedge ACLK) begin
      if (ARESET) begin
         b_pend = 0; r_act = 0; rv_hold = 0; aw_hold = 0; w_hold = 0; ar_hold = 0; wbeat = 0;
      end else begin
         if (aw_hold && !(M_AXI_AWVALID && M_AXI_AWADDR == aw_prev)) stab_viol++;
         if (w_hold && !(M_AXI_WVALID && {M_AXI_WLAST, M_AXI_WDATA} == w_prev)) stab_viol++;
         if (ar_hold && !(M_AXI_ARVALID && M_AXI_ARADDR == ar_prev)) stab_viol++;
         aw_hold = M_AXI_AWVALID && !M_AXI_AWREADY; aw_prev = M_AXI_AWADDR;
         w_hold  = M_AXI_WVALID && !M_AXI_WREADY;   w_prev  = {M_AXI_WLAST, M_AXI_WDATA};
         ar_hold = M_AXI_ARVALID && !M_AXI_ARREADY; ar_prev = M_AXI_ARADDR;
         if (M_AXI_AWVALID && M_AXI_AWREADY) begin
            wr_addr = M_AXI_AWADDR; wbeat = 0; aw_cnt++;
         end
         if (M_AXI_WVALID && M_AXI_WREADY) begin
            mem[8'(int'(wr_addr[9:2]) + wbeat)] = M_AXI_WDATA;
            if (M_AXI_WLAST != (wbeat == 7)) wlast_bad++;
            wbeat++;
            if (M_AXI_WLAST) b_pend = 1;
         end
         if (M_AXI_BVALID && M_AXI_BREADY) begin
            b_pend = 0; b_cnt++;
         end
         if (M_AXI_ARVALID && M_AXI_ARREADY) begin
            rd_addr = M_AXI_ARADDR; rbeat = 0; r_act = 1; ar_cnt++;
         end
         if (M_AXI_RVALID && M_AXI_RREADY) begin
            if (M_AXI_RLAST) r_act = 0;
            rbeat++;
         end
         rv_hold = M_AXI_RVALID && !M_AXI_RREADY;
      end
   end

   always @(negedge ACLK) begin
      int cur_w, cur_r, last_k;
      if (ARESET) begin
         M_AXI_AWREADY = 0; M_AXI_WREADY = 0; M_AXI_ARREADY = 0;
         M_AXI_BVALID = 0; M_AXI_RVALID = 0; M_AXI_RLAST = 0;
      end else begin
         cur_w = aw_cnt - aw0 - 1;
         cur_r = ar_cnt - ar0 - 1;
         M_AXI_AWREADY = bp ? 1'($urandom_range(0, 1)) : 1'b1;
         M_AXI_WREADY  = bp ? 1'($urandom_range(0, 1)) : 1'b1;
         M_AXI_ARREADY = bp ? 1'($urandom_range(0, 1)) : 1'b1;
         M_AXI_BVALID  = b_pend;
         M_AXI_BRESP   = (b_pend && cur_w == bresp_b) ? 2'b10 : 2'b00;
         if (!rv_hold) begin
            last_k = (cur_r == early_b) ? early_k : (cur_r == late_b) ? 8 : 7;
            M_AXI_RVALID = r_act && (bp ? 1'($urandom_range(0, 1)) : 1'b1);
            M_AXI_RDATA  = mem[8'(int'(rd_addr[9:2]) + rbeat)]
                         ^ ((cur_r == flip_b && rbeat == flip_k) ? 32'd1 : 32'd0);
            M_AXI_RLAST  = (rbeat == last_k);
         end
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic start_test(input logic [31:0] b, input logic [7:0] n, input logic [31:0] s);
      @(negedge ACLK);
      aw0 = aw_cnt; ar0 = ar_cnt;
      base_addr = b; num_bursts = n; seed = s; start = 1'b1;
      @(negedge ACLK);
      start = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      int n = 0;
      while (done !== 1'b1 && n < 3000) begin
         @(negedge ACLK);
         n++;
      end
      chk({tag, "_done"}, 64'(done), 64'd1);
      chk({tag, "_busy_low"}, 64'(busy), 64'd0);
   endtask

   initial begin
      int n;
      // Reset values
      repeat (3) @(negedge ACLK);
      chk("rst_ctrl", 64'({busy, done, pass, resp_err}), 64'b0010);
      chk("rst_err_cnt", 64'(err_cnt), 64'd0);
      chk("rst_valids", 64'({M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID,
                             M_AXI_RREADY}), 64'd0);
      ARESET = 1'b0;

      // Basic pass: seed 1, two bursts from 0x0
      start_test(32'h0, 8'd2, 32'd1);
      chk("basic_awvalid_1cyc", 64'(M_AXI_AWVALID), 64'd1);
      chk("basic_awaddr", 64'(M_AXI_AWADDR), 64'h0);
      chk("basic_awlen", 64'(M_AXI_AWLEN), 64'd7);
      chk("basic_busy", 64'(busy), 64'd1);
      wait_done("basic");
      chk("basic_pass", 64'(pass), 64'd1);
      chk("basic_err_cnt", 64'(err_cnt), 64'd0);
      for (int i = 0; i < 16; i++) chk($sformatf("basic_mem%0d", i), 64'(mem[i]), 64'(i + 1));
      chk("basic_reads", 64'(ar_cnt - ar0), 64'd2);

      // Data mismatch: burst 1 beat 3 read back as 13 instead of 12
      flip_b = 1; flip_k = 3;
      start_test(32'h0, 8'd2, 32'd1);
      wait_done("mism");
      chk("mism_err_cnt", 64'(err_cnt), 64'd1);
      chk("mism_pass", 64'(pass), 64'd0);
      chk("mism_resp_err", 64'(resp_err), 64'd0);
      flip_b = -1; flip_k = -1;

      // SLVERR on the first write response; reads must still run
      bresp_b = 0;
      start_test(32'h0, 8'd2, 32'd1);
      wait_done("bresp");
      chk("bresp_resp_err", 64'(resp_err), 64'd1);
      chk("bresp_pass", 64'(pass), 64'd0);
      chk("bresp_err_cnt", 64'(err_cnt), 64'd0);
      chk("bresp_reads", 64'(ar_cnt - ar0), 64'd2);
      bresp_b = -1;

      // Zero bursts: done two cycles after start, no traffic
      start_test(32'h0, 8'd0, 32'd7);
      chk("zero_done_early", 64'(done), 64'd0);
      @(negedge ACLK);
      chk("zero_done_2cyc", 64'(done), 64'd1);
      chk("zero_busy", 64'(busy), 64'd0);
      chk("zero_pass", 64'(pass), 64'd1);
      chk("zero_traffic", 64'((aw_cnt - aw0) + (ar_cnt - ar0)), 64'd0);

      // Early RLAST on burst 0 (beat 5) and missing RLAST on burst 1
      early_b = 0; early_k = 5; late_b = 1;
      start_test(32'h0, 8'd2, 32'd1);
      wait_done("rlast");
      chk("rlast_err_cnt", 64'(err_cnt), 64'd2);
      chk("rlast_resp_err", 64'(resp_err), 64'd0);
      chk("rlast_reads", 64'(ar_cnt - ar0), 64'd2);
      early_b = -1; early_k = -1; late_b = -1;

      // Random backpressure at base 0x40
      bp = 1'b1;
      start_test(32'h40, 8'd2, 32'd1);
      wait_done("bp");
      chk("bp_pass", 64'(pass), 64'd1);
      chk("bp_err_cnt", 64'(err_cnt), 64'd0);
      for (int i = 0; i < 16; i++) chk($sformatf("bp_mem%0d", i), 64'(mem[16 + i]), 64'(i + 1));
      chk("bp_wlast_placement", 64'(wlast_bad), 64'd0);
      chk("bp_payload_stable", 64'(stab_viol), 64'd0);
      bp = 1'b0;

      // Reset during the read pass, then a clean run with seed 0x100
      start_test(32'h0, 8'd3, 32'd5);
      n = 0;
      while (M_AXI_RREADY !== 1'b1 && n < 500) begin
         @(negedge ACLK);
         n++;
      end
      chk("rst_reach_rd_data", 64'(M_AXI_RREADY), 64'd1);
      ARESET = 1'b1;
      @(negedge ACLK);
      ARESET = 1'b0;
      chk("midrst_ctrl", 64'({busy, done, pass, resp_err}), 64'b0010);
      chk("midrst_valids", 64'({M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID,
                                M_AXI_RREADY}), 64'd0);
      chk("midrst_err_cnt", 64'(err_cnt), 64'd0);
      start_test(32'h0, 8'd2, 32'h100);
      wait_done("recov");
      chk("recov_pass", 64'(pass), 64'd1);
      chk("recov_mem0", 64'(mem[0]), 64'h100);
      chk("recov_mem15", 64'(mem[15]), 64'h10F);
      chk("final_payload_stable", 64'(stab_viol), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
